// File: rtl/sdm_fir_decim_pkg.sv
// Shared types, default coefficient ROM and output scaling for the multi-channel SDM FIR decimator.
package fir_decim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PUSH} fir_state_t;

  localparam int unsigned FIR_ROM_DEPTH = 128;
  localparam int unsigned FIR_ROM_AW    = $clog2(FIR_ROM_DEPTH);
  localparam int unsigned FIR_ROM_W     = 16;

  typedef logic [FIR_ROM_DEPTH-1:0][FIR_ROM_W-1:0] fir_rom_t;

  // Half of a triangular window: c[k] = k+1, peaking at the centre tap pair.
  function automatic fir_rom_t build_fir_rom();
    fir_rom_t r;
    r = '0;
    for (int unsigned i = 0; i < FIR_ROM_DEPTH; i++) begin
      r[i[FIR_ROM_AW-1:0]] = FIR_ROM_W'(i + 1);
    end
    return r;
  endfunction

  localparam fir_rom_t FIR_COEF_ROM = build_fir_rom();

  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int unsigned shift,
                                                   input int unsigned ow);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift != 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdm_fir_decim_pair_mac.sv
// Symmetric tap-pair multiply-accumulate for 1-bit inputs; shared by all channels.
module fir_pair_mac #(
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 26
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 bit_a_i,
  input  logic                 bit_b_i,
  input  logic [CW-1:0]        coef_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  output logic signed [AW-1:0] acc_o
);

  logic signed [AW-1:0] acc_q, acc_d, term;

  // Equal bits contribute +/-2*c, differing bits cancel.
  always_comb begin
    term = '0;
    if (bit_a_i == bit_b_i) begin
      term = AW'($signed(coef_i)) <<< 1;
      if (!bit_a_i) begin
        term = -term;
      end
    end
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + term;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sdm_fir_decim.sv
// NCH-channel symmetric FIR over 1-bit SDM streams with one time-shared pair MAC.
// FIR_COEF_WR_EN adds a writable coefficient register file in place of the fixed ROM.
module sdm_fir_decim
  import fir_decim_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned NTAPS = 256,
  parameter int unsigned CW    = 16,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic                                      Clock,
  input  logic                                      Reset,
  input  logic                                      BitEn,
  input  logic [NCH-1:0]                            BitIn,
  input  logic                                      FILTER,
`ifdef FIR_COEF_WR_EN
  input  logic                                      CoefWe,
  input  logic [$clog2(NTAPS/2)-1:0]                CoefAddr,
  input  logic [CW-1:0]                             CoefData,
`endif
  output logic [OW-1:0]                             Dout,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  DoutCh,
  output logic                                      Push,
  output logic                                      Busy,
  output logic                                      Overrun
);

  localparam int unsigned HALF = NTAPS / 2;
  localparam int unsigned KW   = $clog2(HALF);
  localparam int unsigned TW   = $clog2(NTAPS);
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW   = CW + TW + 2;

  fir_state_t state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [NCH-1:0][NTAPS-1:0] hist_q, hist_sh, snap_q;
  logic [HALF-1:0][CW-1:0]   coef_rom;
  logic [OW-1:0]  dout_q;
  logic [CHW-1:0] doutch_q;
  logic           push_q, ovr_q;
  logic           mac_clr, mac_en, snap_load, push_load, ovr_set;
  logic [CW-1:0]  coef;
  logic [TW-1:0]  k_far;
  logic signed [AW-1:0] mac_acc;

  for (genvar c = 0; c < NCH; c++) begin : g_hist
    assign hist_sh[c] = {hist_q[c][NTAPS-2:0], BitIn[c]};
  end

  for (genvar i = 0; i < HALF; i++) begin : g_rom
    assign coef_rom[i] = CW'($signed(FIR_COEF_ROM[i]));
  end

`ifdef FIR_COEF_WR_EN
  logic [HALF-1:0][CW-1:0] coef_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      coef_q <= coef_rom;
    end else if (CoefWe) begin
      coef_q[CoefAddr] <= CoefData;
    end
  end

  assign coef = coef_q[k_q];
`else
  assign coef = coef_rom[k_q];
`endif

  assign k_far = TW'(NTAPS - 1) - TW'(k_q);

  fir_pair_mac #(
    .CW (CW),
    .AW (AW)
  ) u_mac (
    .Clock   (Clock),
    .Reset   (Reset),
    .bit_a_i (snap_q[ch_q][k_q]),
    .bit_b_i (snap_q[ch_q][k_far]),
    .coef_i  (coef),
    .clr_i   (mac_clr),
    .en_i    (mac_en),
    .acc_o   (mac_acc)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ch_d      = ch_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    snap_load = 1'b0;
    push_load = 1'b0;
    ovr_set   = FILTER && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (FILTER) begin
          snap_load = 1'b1;
          mac_clr   = 1'b1;
          k_d       = '0;
          ch_d      = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        mac_en = 1'b1;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(HALF - 1)) begin
          k_d     = '0;
          state_d = PUSH;
        end
      end
      PUSH: begin
        push_load = 1'b1;
        mac_clr   = 1'b1;
        k_d       = '0;
        if (ch_q == CHW'(NCH - 1)) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot takes the pre-edge history, so a bit shifted in with FILTER is excluded.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      ch_q     <= '0;
      hist_q   <= '0;
      snap_q   <= '0;
      dout_q   <= '0;
      doutch_q <= '0;
      push_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ch_q    <= ch_d;
      push_q  <= push_load;
      if (BitEn) begin
        hist_q <= hist_sh;
      end
      if (snap_load) begin
        snap_q <= hist_q;
      end
      if (push_load) begin
        dout_q   <= OW'(sat_round(64'(mac_acc), SHIFT, OW));
        doutch_q <= ch_q;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign Dout    = dout_q;
  assign DoutCh  = doutch_q;
  assign Push    = push_q;
  assign Busy    = (state_q != IDLE);
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_sdm_fir_decim.sv
// Scoreboard bench for sdm_fir_decim; adapts to FIR_COEF_WR_EN (writable coefficients) or the fixed ROM.
module tb_sdm_fir_decim;

  localparam int NCH   = 2;
  localparam int NTAPS = 256;
  localparam int HALF  = NTAPS / 2;
  localparam int CW    = 16;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RUNLEN = HALF + 1;
`ifdef FIR_COEF_WR_EN
  localparam int OW    = 16;
  localparam int SHIFT = 0;
`else
  localparam int OW    = 12;
  localparam int SHIFT = 3;
`endif

  typedef struct {
    logic [OW-1:0]  dout;
    logic [CHW-1:0] ch;
    int             cyc;
  } exp_t;

  logic             Clock;
  logic             Reset;
  logic             BitEn;
  logic [NCH-1:0]   BitIn;
  logic             FILTER;
  logic [OW-1:0]    Dout;
  logic [CHW-1:0]   DoutCh;
  logic             Push;
  logic             Busy;
  logic             Overrun;
`ifdef FIR_COEF_WR_EN
  logic             CoefWe;
  logic [$clog2(HALF)-1:0] CoefAddr;
  logic [CW-1:0]    CoefData;
`endif

  sdm_fir_decim #(
    .NCH   (NCH),
    .NTAPS (NTAPS),
    .CW    (CW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .BitEn    (BitEn),
    .BitIn    (BitIn),
    .FILTER   (FILTER),
`ifdef FIR_COEF_WR_EN
    .CoefWe   (CoefWe),
    .CoefAddr (CoefAddr),
    .CoefData (CoefData),
`endif
    .Dout     (Dout),
    .DoutCh   (DoutCh),
    .Push     (Push),
    .Busy     (Busy),
    .Overrun  (Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int pushes = 0;
  int busy_until = -1000;
  int acc_edge = 0;
  logic ovr_exp = 1'b0;
  logic [NTAPS-1:0] mh [NCH];
  int mc [HALF];
  exp_t sbq[$];
  exp_t mon_e;

  function automatic longint model_acc(input logic [NTAPS-1:0] h);
    longint a = 0;
    for (int j = 0; j < NTAPS; j++) begin
      longint cf = mc[(j < HALF) ? j : (NTAPS - 1 - j)];
      a += h[j] ? cf : -cf;
    end
    return a;
  endfunction

  function automatic logic [OW-1:0] model_out(input longint acc);
    longint r  = (acc + ((longint'(1) <<< SHIFT) >>> 1)) >>> SHIFT;
    longint hi = (longint'(1) <<< (OW - 1)) - 1;
    longint lo = -(longint'(1) <<< (OW - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r[OW-1:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) mh[c] = '0;
    for (int k = 0; k < HALF; k++) mc[k] = k + 1;
    sbq.delete();
    busy_until = -1000;
    ovr_exp = 1'b0;
  endtask

  task automatic drive(input logic [NCH-1:0] bits, input logic en, input logic flt);
    int e;
    exp_t x;
    BitIn = bits;
    BitEn = en;
    FILTER = flt;
    @(posedge Clock);
    #1;
    e = cyc;
    if (flt && Reset) begin
      if (e > busy_until) begin
        for (int c = 0; c < NCH; c++) begin
          x.dout = model_out(model_acc(mh[c]));
          x.ch   = CHW'(c);
          x.cyc  = e + (c + 1) * RUNLEN;
          sbq.push_back(x);
        end
        busy_until = e + NCH * RUNLEN;
        acc_edge = e;
      end else begin
        ovr_exp = 1'b1;
      end
    end
    if (en && Reset) begin
      for (int c = 0; c < NCH; c++) mh[c] = {mh[c][NTAPS-2:0], bits[c]};
    end
    BitEn = 1'b0;
    FILTER = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sbq.size() != 0 || Busy !== 1'b0) && n < 2 * NCH * RUNLEN + 50) begin
      drive('0, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (sbq.size() != 0 || Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d busy=%b required pending=0 busy=0", tag, sbq.size(), Busy);
    end
  endtask

`ifdef FIR_COEF_WR_EN
  task automatic write_coefs(input int base, input int step);
    for (int k = 0; k < HALF; k++) begin
      logic [CW-1:0] v;
      v = CW'(base + step * k);
      CoefWe = 1'b1;
      CoefAddr = k[$clog2(HALF)-1:0];
      CoefData = v;
      mc[k] = int'($signed(v));
      drive('0, 1'b0, 1'b0);
    end
    CoefWe = 1'b0;
  endtask
`endif

  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      if (Push !== 1'b0 && Push !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL push_x Push=%b required 0 or 1", Push);
      end else if (Push) begin
        pushes++;
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL push_unexpected cyc=%0d Dout=%h DoutCh=%0d required no Push", cyc, Dout, DoutCh);
        end else begin
          mon_e = sbq.pop_front();
          if (Dout !== mon_e.dout || DoutCh !== mon_e.ch || cyc != mon_e.cyc) begin
            bad++;
            $display("FAIL push_result Dout=%h DoutCh=%0d cyc=%0d required Dout=%h DoutCh=%0d cyc=%0d",
                     Dout, DoutCh, cyc, mon_e.dout, mon_e.ch, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    total++;
    if ({Dout, DoutCh, Push, Busy, Overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs Dout=%h DoutCh=%0d Push=%b Busy=%b Overrun=%b required all 0",
               Dout, DoutCh, Push, Busy, Overrun);
    end
    Reset = 1'b1;
    drive('0, 1'b0, 1'b0);
    total++;
    if (Busy !== 1'b0 || Push !== 1'b0) begin
      bad++;
      $display("FAIL reset_release Busy=%b Push=%b required 0 0", Busy, Push);
    end
  endtask

  task automatic test_ones_zeros();
    int p0;
`ifdef FIR_COEF_WR_EN
    write_coefs(1, 0);
`endif
    repeat (NTAPS) drive(NCH'(1), 1'b1, 1'b0);
    p0 = pushes;
    drive('0, 1'b0, 1'b1);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL ones_zeros_busy Busy=%b required 1", Busy);
    end
    wait_done("ones_zeros");
    total++;
    if (pushes - p0 != NCH) begin
      bad++;
      $display("FAIL ones_zeros_count pushes=%0d required %0d", pushes - p0, NCH);
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < NTAPS; i++) drive({NCH{i[0]}}, 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    wait_done("alternating");
  endtask

  task automatic test_saturation();
`ifdef FIR_COEF_WR_EN
    write_coefs(32767, 0);
`endif
    repeat (NTAPS) drive(NCH'(1), 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    wait_done("sat_a");
    repeat (NTAPS) drive(~NCH'(1), 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    wait_done("sat_b");
`ifdef FIR_COEF_WR_EN
    write_coefs(-60, 1);
`endif
  endtask

  task automatic test_overrun();
    int p0;
    repeat (NTAPS) drive(NCH'($urandom), 1'b1, 1'b0);
    total++;
    if (Overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_initial Overrun=%b required 0", Overrun);
    end
    p0 = pushes;
    drive(NCH'($urandom), 1'b1, 1'b1);
    repeat (9) drive(NCH'($urandom), 1'b1, 1'b0);
    drive(NCH'($urandom), 1'b1, 1'b1);
    total++;
    if (Overrun !== ovr_exp || Overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set Overrun=%b required 1", Overrun);
    end
    while (cyc + 1 < acc_edge + NCH * RUNLEN) drive(NCH'($urandom), 1'b1, 1'b0);
    drive(NCH'($urandom), 1'b1, 1'b1);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL overrun_final_push_filter Busy=%b required 0", Busy);
    end
    total++;
    if (pushes - p0 != NCH - 1) begin
      bad++;
      $display("FAIL overrun_count pushes=%0d required %0d", pushes - p0, NCH - 1);
    end
    drive(NCH'($urandom), 1'b1, 1'b1);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL overrun_restart Busy=%b required 1", Busy);
    end
    wait_done("overrun");
    total++;
    if (pushes - p0 != 2 * NCH) begin
      bad++;
      $display("FAIL overrun_total pushes=%0d required %0d", pushes - p0, 2 * NCH);
    end
  endtask

  task automatic test_reset_mid_run();
    int p0;
    repeat (NTAPS) drive(NCH'($urandom), 1'b1, 1'b0);
    drive(NCH'($urandom), 1'b1, 1'b1);
    repeat (50) drive(NCH'($urandom), 1'b1, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    model_clear();
    total++;
    if ({Dout, DoutCh, Push, Busy, Overrun} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_async Dout=%h DoutCh=%0d Push=%b Busy=%b Overrun=%b required all 0",
               Dout, DoutCh, Push, Busy, Overrun);
    end
    repeat (3) begin
      drive('0, 1'b0, 1'b0);
      total++;
      if (Push !== 1'b0 || Busy !== 1'b0) begin
        bad++;
        $display("FAIL midrun_reset_hold Push=%b Busy=%b required 0 0", Push, Busy);
      end
    end
    Reset = 1'b1;
    p0 = pushes;
    repeat (2 * RUNLEN) drive('0, 1'b0, 1'b0);
    total++;
    if (pushes != p0 || Overrun !== 1'b0) begin
      bad++;
      $display("FAIL midrun_no_push pushes=%0d Overrun=%b required 0 0", pushes - p0, Overrun);
    end
    repeat (NTAPS) drive(NCH'($urandom), 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    wait_done("midrun_after");
  endtask

  task automatic test_periodic();
    int p0;
    p0 = pushes;
    for (int p = 0; p < 6; p++) begin
      drive(NCH'($urandom), 1'b1, 1'b1);
      repeat (279) drive(NCH'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    wait_done("periodic");
    total++;
    if (pushes - p0 != 6 * NCH) begin
      bad++;
      $display("FAIL periodic_count pushes=%0d required %0d", pushes - p0, 6 * NCH);
    end
  endtask

  initial begin
    BitEn = 1'b0;
    BitIn = '0;
    FILTER = 1'b0;
`ifdef FIR_COEF_WR_EN
    CoefWe = 1'b0;
    CoefAddr = '0;
    CoefData = '0;
`endif
    model_clear();
    test_reset();
    test_ones_zeros();
    test_alternating();
    test_saturation();
    test_overrun();
    test_reset_mid_run();
    test_periodic();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL final_pending pending=%0d required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
